uart_rx_controller: RTL and testbench

Frame-level controller for the UART receive path. Detects the start-bit edge on the serial line and arms the sampling strobe generator. Uses the returned mid-bit strobes to validate the start bit, shift in the data bits and check the stop bit. Delivers each received byte on a valid/ready output interface, with framing and overrun error reporting. It sits between the Rx pin and the byte consumer, and is the only block that drives `start_detected`.

---
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_rx_controller.sv | 142 ++++++++++++++
 tb/tb_uart_rx_controller.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Received-byte stream between the UART receive controller and its consumer.
// The master side presents data with valid; the slave side accepts it with ready.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_controller.sv
// UART receive frame controller: start-edge detection, strobe-driven bit capture,
// stop-bit check and valid/ready byte delivery with framing/overrun reporting.
module uart_rx_controller #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    input  logic          sampling_strobe,
    output logic          start_detected,
    output logic          framing_error,
    output logic          overrun_error,
    output logic          busy,
    uart_rx_if.master     rx_out
);

    localparam int unsigned CntW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_s_d;
    logic                   strobe;

    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]      bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 start_q, start_d;
    logic                 fe_q, fe_d;
    logic                 oe_q, oe_d;
    logic                 busy_q;

    assign rx_s = sync_q[SYNC_STAGES-1];
    // A strobe landing with the re-phase pulse belongs to the old phase; drop it.
    assign strobe = sampling_strobe & ~start_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            rx_s_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_s_d <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            fe_q     <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            fe_q     <= fe_d;
            oe_q     <= oe_d;
            busy_q   <= (state_d != StIdle);
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        data_d   = data_q;
        valid_d  = valid_q & ~rx_out.rx_ready;
        start_d  = 1'b0;
        fe_d     = 1'b0;
        oe_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_s_d && !rx_s) begin
                    start_d = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (strobe) begin
                    if (!rx_s) begin
                        bitcnt_d = '0;
                        state_d  = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (strobe) begin
                    shreg_d  = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == LastBit) state_d = StStop;
                end
            end
            StStop: begin
                if (strobe) begin
                    if (rx_s) begin
                        // Consumer taking the old byte this edge frees the slot.
                        if (!valid_q || rx_out.rx_ready) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            oe_d = 1'b1;
                        end
                        state_d = StIdle;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign start_detected  = start_q;
    assign framing_error   = fe_q;
    assign overrun_error   = oe_q;
    assign busy            = busy_q;
    assign rx_out.rx_data  = data_q;
    assign rx_out.rx_valid = valid_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: a queue of expected bytes is filled by the
// stimulus and drained by a monitor on every valid/ready transfer.
module tb_uart_rx_controller;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic sampling_strobe = 1'b0;
    logic start_detected, framing_error, overrun_error, busy;

    uart_rx_if #(.DATA_BITS(8)) rx_bus ();

    uart_rx_controller #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx),
        .sampling_strobe (sampling_strobe),
        .start_detected  (start_detected),
        .framing_error   (framing_error),
        .overrun_error   (overrun_error),
        .busy            (busy),
        .rx_out          (rx_bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    int sd_cnt = 0, fe_cnt = 0, oe_cnt = 0, vld_cyc = 0;
    int s_sd, s_fe, s_oe, s_vld;
    logic sd_prev = 1'b0, fe_prev = 1'b0, oe_prev = 1'b0;
    int cnt = 0;

    // Strobe generator model: re-phased by start_detected, fires near mid-bit.
    always @(posedge clk) begin
        if (start_detected) begin
            cnt <= HALF;
            sampling_strobe <= 1'b0;
        end else if (cnt == CPB - 1) begin
            cnt <= 0;
            sampling_strobe <= 1'b1;
        end else begin
            cnt <= cnt + 1;
            sampling_strobe <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (start_detected) begin
            sd_cnt++;
            check("start_detected_width", {31'd0, sd_prev}, 32'd0);
        end
        if (framing_error) begin
            fe_cnt++;
            check("framing_error_width", {31'd0, fe_prev}, 32'd0);
        end
        if (overrun_error) begin
            oe_cnt++;
            check("overrun_error_width", {31'd0, oe_prev}, 32'd0);
        end
        if (rx_bus.rx_valid) vld_cyc++;
        if (rx_bus.rx_valid && rx_bus.rx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", {24'd0, rx_bus.rx_data}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("transfer_data", {24'd0, rx_bus.rx_data}, {24'd0, e});
            end
        end
        sd_prev = start_detected;
        fe_prev = framing_error;
        oe_prev = overrun_error;
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = stop;
        wait_cycles(CPB);
    endtask

    // Returns in the cycle where the n-th strobe after start_detected is presented.
    task automatic wait_strobe_n(input int n, output logic ok);
        int seen = 0;
        int cyc  = 0;
        while (!start_detected && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        while (seen < n && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sampling_strobe) seen++;
        end
        ok = (seen == n);
    endtask

    task automatic snap();
        s_sd  = sd_cnt;
        s_fe  = fe_cnt;
        s_oe  = oe_cnt;
        s_vld = vld_cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic ok;
        rx_bus.rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {19'd0, start_detected, rx_bus.rx_valid, framing_error,
                                overrun_error, busy, rx_bus.rx_data}, 32'd0);
        reset = 1'b0;
        wait_cycles(2 * CPB);

        // Normal frame
        rx_bus.rx_ready = 1'b1;
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_cycles(CPB);
        check("normal_start_pulses", sd_cnt - s_sd, 1);
        check("normal_valid_cycles", vld_cyc - s_vld, 1);
        check("normal_fe", fe_cnt - s_fe, 0);
        check("normal_oe", oe_cnt - s_oe, 0);
        check("normal_busy", {31'd0, busy}, 0);
        check("normal_queue", exp_q.size(), 0);

        // Glitch rejection
        snap();
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        check("glitch_start_pulses", sd_cnt - s_sd, 1);
        check("glitch_valid_cycles", vld_cyc - s_vld, 0);
        check("glitch_fe", fe_cnt - s_fe, 0);
        check("glitch_busy", {31'd0, busy}, 0);

        // Framing error then break
        snap();
        send_frame(8'h3C, 1'b0);
        wait_cycles(4 * CPB);
        check("break_busy", {31'd0, busy}, 1);
        check("break_start_pulses", sd_cnt - s_sd, 1);
        check("break_fe", fe_cnt - s_fe, 1);
        check("break_valid_cycles", vld_cyc - s_vld, 0);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        check("break_idle_busy", {31'd0, busy}, 0);
        snap();
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_cycles(CPB);
        check("after_break_valid_cycles", vld_cyc - s_vld, 1);
        check("after_break_queue", exp_q.size(), 0);

        // Overrun
        rx_bus.rx_ready = 1'b0;
        snap();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(CPB);
        check("overrun_data", {24'd0, rx_bus.rx_data}, 32'h11);
        check("overrun_valid", {31'd0, rx_bus.rx_valid}, 1);
        check("overrun_pulses", oe_cnt - s_oe, 1);
        check("overrun_start_pulses", sd_cnt - s_sd, 2);
        rx_bus.rx_ready = 1'b1;
        wait_cycles(1);
        check("overrun_drain_valid", {31'd0, rx_bus.rx_valid}, 0);
        check("overrun_queue", exp_q.size(), 0);

        // Load during transfer
        rx_bus.rx_ready = 1'b0;
        snap();
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        wait_cycles(CPB);
        check("hold_data", {24'd0, rx_bus.rx_data}, 32'h55);
        exp_q.push_back(8'h66);
        fork
            send_frame(8'h66, 1'b1);
            begin
                wait_strobe_n(10, ok);
                check("load_stop_strobe_seen", {31'd0, ok}, 1);
                rx_bus.rx_ready = 1'b1;
                wait_cycles(1);
                rx_bus.rx_ready = 1'b0;
                check("load_valid", {31'd0, rx_bus.rx_valid}, 1);
                check("load_data", {24'd0, rx_bus.rx_data}, 32'h66);
            end
        join
        check("load_oe", oe_cnt - s_oe, 0);
        rx_bus.rx_ready = 1'b1;
        wait_cycles(2);
        check("load_drain_valid", {31'd0, rx_bus.rx_valid}, 0);
        check("load_queue", exp_q.size(), 0);

        // Reset mid-frame
        snap();
        fork
            send_frame(8'hF0, 1'b1);
            begin
                wait_strobe_n(6, ok);
                check("reset_strobe_seen", {31'd0, ok}, 1);
                reset = 1'b1;
                #1;
                check("midframe_reset_outputs", {19'd0, start_detected, rx_bus.rx_valid,
                      framing_error, overrun_error, busy, rx_bus.rx_data}, 32'd0);
                wait_cycles(1);
                reset = 1'b0;
            end
        join
        wait_cycles(CPB);
        check("reset_no_valid", vld_cyc - s_vld, 0);
        check("reset_no_fe", fe_cnt - s_fe, 0);
        check("reset_busy", {31'd0, busy}, 0);
        snap();
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        wait_cycles(CPB);
        check("post_reset_valid_cycles", vld_cyc - s_vld, 1);
        check("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
